// File: rtl/llc_multi.sv
// Multi-filter CAN logic link control: TX sequencing plus NUM_FILT acceptance filters with per-mailbox overflow.
// Optional LLC_MULTI_PROMISCUOUS_EN adds a 'promiscous' input that routes every received frame to mailbox 0.
module llc_multi #(
  parameter  int NUM_FILT = 4,
  localparam int IDX_W    = $clog2(NUM_FILT)
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef LLC_MULTI_PROMISCUOUS_EN
  input  logic                  promiscous,
`endif
  input  logic                  initreqr,
  input  logic                  traregbit,
  input  logic                  sucfrecvc,
  input  logic                  sucftranc,
  input  logic                  sucfrecvr,
  input  logic                  sucftranr,
  input  logic                  extended,
  input  logic [28:0]           idrec,
  input  logic [29*NUM_FILT-1:0] filt_id,
  input  logic [29*NUM_FILT-1:0] filt_mask,
  input  logic [NUM_FILT-1:0]   filt_ext,
  input  logic [NUM_FILT-1:0]   filt_en,
  input  logic [NUM_FILT-1:0]   mbx_full,
  output logic                  activtreg,
  output logic [NUM_FILT-1:0]   activrreg,
  output logic                  activgreg,
  output logic                  ldrecid,
  output logic [IDX_W-1:0]      hit_idx,
  output logic                  sucftrano,
  output logic                  sucfrecvo,
  output logic [NUM_FILT-1:0]   overflowo,
  output logic                  trans,
  output logic                  load,
  output logic                  actvtsft,
  output logic                  actvtcap,
  output logic                  resettra,
  output logic                  resetall
);

  typedef enum logic [2:0] {
    RESET, IDLE, TX_LOAD, TX_ACTIVE, TX_DONE, RX_CHECK, RX_STORE
  } state_t;

  state_t             state, state_nxt;
  logic               tx_pending, tx_pending_nxt;
  logic [NUM_FILT-1:0] match_p0;
  logic [IDX_W-1:0]   hit_idx_p0, hit_idx_p1;

  // Standard frames carry their 11-bit identifier in bits [28:18].
  function automatic logic filt_hit(input logic [28:0] id, input logic ext,
                                    input logic [28:0] fid, input logic [28:0] fmask,
                                    input logic fext, input logic fen);
    logic [28:0] cmpmask;
    cmpmask = ext ? 29'h1FFF_FFFF : 29'h1FFC_0000;
    return fen && (fext == ext) && (((id ^ fid) & fmask & cmpmask) == 29'h0);
  endfunction

  // Stage p0: filter compare and lowest-index priority encode
  always_comb begin
    match_p0 = '0;
    for (int k = 0; k < NUM_FILT; k++)
      match_p0[k] = filt_hit(idrec, extended, filt_id[29*k +: 29], filt_mask[29*k +: 29],
                             filt_ext[k], filt_en[k]);
`ifdef LLC_MULTI_PROMISCUOUS_EN
    if (promiscous)
      match_p0 = NUM_FILT'(1);
`endif
    hit_idx_p0 = '0;
    for (int k = NUM_FILT - 1; k >= 0; k--)
      if (match_p0[k])
        hit_idx_p0 = IDX_W'(k);
  end

  // Stage p1: state, pending-transmit flag and registered hit index
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tx_pending <= 1'b0;
      hit_idx_p1 <= '0;
    end else begin
      state      <= state_nxt;
      tx_pending <= tx_pending_nxt;
      if (state == RX_CHECK)
        hit_idx_p1 <= hit_idx_p0;
    end
  end

  assign hit_idx = hit_idx_p1;

  always_comb begin
    state_nxt      = state;
    tx_pending_nxt = tx_pending;
    case (state)
      RESET:     state_nxt = IDLE;
      IDLE: begin
        if (sucfrecvc)      state_nxt = RX_CHECK;
        else if (traregbit) state_nxt = TX_LOAD;
      end
      TX_LOAD:   state_nxt = TX_ACTIVE;
      TX_ACTIVE: begin
        if (sucftranc) begin
          state_nxt = TX_DONE;
        end else if (sucfrecvc) begin
          state_nxt      = RX_CHECK;
          tx_pending_nxt = 1'b1;
        end
      end
      TX_DONE:   state_nxt = IDLE;
      RX_CHECK: begin
        if (|match_p0) begin
          state_nxt = RX_STORE;
        end else begin
          state_nxt      = (tx_pending && traregbit) ? TX_LOAD : IDLE;
          tx_pending_nxt = 1'b0;
        end
      end
      RX_STORE: begin
        state_nxt      = (tx_pending && traregbit) ? TX_LOAD : IDLE;
        tx_pending_nxt = 1'b0;
      end
      default:   state_nxt = IDLE;
    endcase
    if (initreqr) begin
      state_nxt      = RESET;
      tx_pending_nxt = 1'b0;
    end
  end

  always_comb begin
    activtreg = 1'b0;
    activrreg = '0;
    activgreg = 1'b0;
    ldrecid   = 1'b0;
    sucftrano = 1'b0;
    sucfrecvo = 1'b0;
    overflowo = '0;
    trans     = 1'b0;
    load      = 1'b0;
    actvtsft  = 1'b0;
    actvtcap  = 1'b0;
    resettra  = 1'b0;
    resetall  = 1'b0;
    case (state)
      RESET: begin
        resettra = 1'b1;
        resetall = 1'b1;
      end
      TX_LOAD: begin
        load     = 1'b1;
        actvtsft = 1'b1;
        actvtcap = 1'b1;
      end
      TX_ACTIVE: begin
        trans    = 1'b1;
        actvtsft = 1'b1;
        actvtcap = 1'b1;
      end
      TX_DONE: begin
        sucftrano = 1'b1;
        sucfrecvo = sucfrecvr;
        activtreg = 1'b1;
        activgreg = 1'b1;
        resettra  = 1'b1;
      end
      RX_STORE: begin
        activrreg[hit_idx_p1] = 1'b1;
        activgreg             = 1'b1;
        sucfrecvo             = 1'b1;
        sucftrano             = sucftranr;
        // A full mailbox keeps its old frame; flag the loss instead of loading.
        if (mbx_full[hit_idx_p1]) overflowo[hit_idx_p1] = 1'b1;
        else                      ldrecid               = 1'b1;
      end
      default: ;
    endcase
    // The MAC is also held in reset during the controller's own reset cycle.
    if (reset) begin
      resettra = 1'b1;
      resetall = 1'b1;
    end
  end

endmodule

// File: tb/tb_llc_multi.sv
// Directed bench for llc_multi (default build, four filters) with hand-computed expectations.
module tb_llc_multi;

  localparam int NF = 4;

  logic          clock = 1'b0;
  logic          reset, initreqr, traregbit, sucfrecvc, sucftranc, sucfrecvr, sucftranr, extended;
  logic [28:0]   idrec;
  logic [29*NF-1:0] filt_id, filt_mask;
  logic [NF-1:0] filt_ext, filt_en, mbx_full;
  logic          activtreg, activgreg, ldrecid, sucftrano, sucfrecvo;
  logic [NF-1:0] activrreg, overflowo;
  logic [1:0]    hit_idx;
  logic          trans, load, actvtsft, actvtcap, resettra, resetall;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [10:0] C_TRANS = 11'h400, C_LOAD = 11'h200, C_SFT = 11'h100, C_CAP = 11'h080,
                          C_RTRA = 11'h040, C_RALL = 11'h020, C_ATREG = 11'h010, C_AGREG = 11'h008,
                          C_LDID = 11'h004, C_STRAN = 11'h002, C_SRECV = 11'h001;

  wire [10:0] ctl = {trans, load, actvtsft, actvtcap, resettra, resetall,
                     activtreg, activgreg, ldrecid, sucftrano, sucfrecvo};

  llc_multi #(.NUM_FILT(NF)) dut (
    .clock(clock), .reset(reset), .initreqr(initreqr), .traregbit(traregbit),
    .sucfrecvc(sucfrecvc), .sucftranc(sucftranc), .sucfrecvr(sucfrecvr), .sucftranr(sucftranr),
    .extended(extended), .idrec(idrec), .filt_id(filt_id), .filt_mask(filt_mask),
    .filt_ext(filt_ext), .filt_en(filt_en), .mbx_full(mbx_full),
    .activtreg(activtreg), .activrreg(activrreg), .activgreg(activgreg), .ldrecid(ldrecid),
    .hit_idx(hit_idx), .sucftrano(sucftrano), .sucfrecvo(sucfrecvo), .overflowo(overflowo),
    .trans(trans), .load(load), .actvtsft(actvtsft), .actvtcap(actvtcap),
    .resettra(resettra), .resetall(resetall)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse sucfrecvc for one sampled edge; afterwards the DUT is in RX_CHECK.
  task automatic rx_pulse(input logic [28:0] id, input logic ext);
    idrec     = id;
    extended  = ext;
    sucfrecvc = 1'b1;
    cyc();
    sucfrecvc = 1'b0;
  endtask

  initial begin
    reset = 1'b1; initreqr = 1'b0; traregbit = 1'b0; sucfrecvc = 1'b0; sucftranc = 1'b0;
    sucfrecvr = 1'b0; sucftranr = 1'b0; extended = 1'b0; idrec = '0; mbx_full = '0;
    // f0 std 0x555, f1 ext 0x0ABCDExx, f2 std 0x123 (full mask), f3 ext 0x0ABCxxxx
    filt_id   = {29'h0ABC_0000, 29'h048C_0000, 29'h0ABC_DE00, 29'h1554_0000};
    filt_mask = {29'h1FFF_0000, 29'h1FFF_FFFF, 29'h1FFF_FF00, 29'h1FFC_0000};
    filt_ext  = 4'b1010;
    filt_en   = 4'b1111;

    cyc();
    chk("reset_ctl", 32'(ctl), 32'(C_RTRA | C_RALL));
    chk("reset_hit", 32'(hit_idx), 32'd0);
    reset = 1'b0;
    cyc();
    chk("idle_ctl", 32'(ctl), 32'd0);
    chk("idle_rreg", 32'(activrreg), 32'd0);

    // Standard 0x123 with junk low bits: only [28:18] compared, filter 2 hits
    sucftranr = 1'b1;
    rx_pulse(29'h048F_FFFF, 1'b0);
    chk("std_check_ctl", 32'(ctl), 32'd0);
    cyc();
    chk("std_store_ctl", 32'(ctl), 32'(C_AGREG | C_LDID | C_STRAN | C_SRECV));
    chk("std_store_rreg", 32'(activrreg), 32'h4);
    chk("std_store_hit", 32'(hit_idx), 32'd2);
    chk("std_store_ovf", 32'(overflowo), 32'd0);
    sucftranr = 1'b0;
    cyc();
    chk("std_after_ctl", 32'(ctl), 32'd0);
    chk("std_after_rreg", 32'(activrreg), 32'd0);

    // Extended frame matching filters 1 and 3: lowest wins
    rx_pulse(29'h0ABC_DE12, 1'b1);
    cyc();
    chk("ext_store_ctl", 32'(ctl), 32'(C_AGREG | C_LDID | C_SRECV));
    chk("ext_store_rreg", 32'(activrreg), 32'h2);
    chk("ext_store_hit", 32'(hit_idx), 32'd1);
    cyc();

    // Same frame, mailbox 1 full
    mbx_full = 4'b0010;
    rx_pulse(29'h0ABC_DE12, 1'b1);
    cyc();
    chk("ovf_store_ctl", 32'(ctl), 32'(C_AGREG | C_SRECV));
    chk("ovf_store_rreg", 32'(activrreg), 32'h2);
    chk("ovf_store_ovf", 32'(overflowo), 32'h2);
    cyc();
    mbx_full = 4'b0000;

    // Filter 1 disabled: filter 3 takes the frame
    filt_en = 4'b1101;
    rx_pulse(29'h0ABC_DE12, 1'b1);
    cyc();
    chk("dis_store_rreg", 32'(activrreg), 32'h8);
    chk("dis_store_hit", 32'(hit_idx), 32'd3);
    cyc();
    filt_en = 4'b1111;

    // Extended frame matching nothing: no strobes, IDLE at t+2
    rx_pulse(29'h0123_4567, 1'b1);
    chk("nom_check_ctl", 32'(ctl), 32'd0);
    cyc();
    chk("nom_after_ctl", 32'(ctl), 32'd0);
    chk("nom_after_rreg", 32'(activrreg), 32'd0);

    // Transmit, with a simultaneous own-frame receive dropped
    traregbit = 1'b1;
    cyc();
    chk("tx_load_ctl", 32'(ctl), 32'(C_LOAD | C_SFT | C_CAP));
    traregbit = 1'b0;
    cyc();
    chk("tx_act1_ctl", 32'(ctl), 32'(C_TRANS | C_SFT | C_CAP));
    cyc();
    chk("tx_act2_ctl", 32'(ctl), 32'(C_TRANS | C_SFT | C_CAP));
    sucftranc = 1'b1; sucfrecvc = 1'b1; sucfrecvr = 1'b1;
    cyc();
    sucftranc = 1'b0; sucfrecvc = 1'b0;
    chk("tx_done_ctl", 32'(ctl), 32'(C_STRAN | C_SRECV | C_ATREG | C_AGREG | C_RTRA));
    sucfrecvr = 1'b0;
    cyc();
    chk("tx_after_ctl", 32'(ctl), 32'd0);

    // Arbitration lost: receive completes, then transmit restarts
    traregbit = 1'b1;
    cyc();
    cyc();
    chk("arb_act_ctl", 32'(ctl), 32'(C_TRANS | C_SFT | C_CAP));
    rx_pulse(29'h048C_0000, 1'b0);
    chk("arb_check_ctl", 32'(ctl), 32'd0);
    cyc();
    chk("arb_store_rreg", 32'(activrreg), 32'h4);
    chk("arb_store_ctl", 32'(ctl), 32'(C_AGREG | C_LDID | C_SRECV));
    cyc();
    chk("arb_reload_ctl", 32'(ctl), 32'(C_LOAD | C_SFT | C_CAP));
    cyc();
    chk("arb_act2_ctl", 32'(ctl), 32'(C_TRANS | C_SFT | C_CAP));

    // Init request mid-transmit aborts without TX_DONE
    initreqr = 1'b1;
    sucftranc = 1'b1;
    cyc();
    sucftranc = 1'b0;
    chk("init_rst1_ctl", 32'(ctl), 32'(C_RTRA | C_RALL));
    cyc();
    chk("init_rst2_ctl", 32'(ctl), 32'(C_RTRA | C_RALL));
    initreqr = 1'b0;
    traregbit = 1'b0;
    cyc();
    chk("init_idle_ctl", 32'(ctl), 32'd0);

    // Receive beats transmit in IDLE; no pending flag, so IDLE after no-match
    traregbit = 1'b1;
    rx_pulse(29'h0123_4567, 1'b1);
    chk("prio_check_ctl", 32'(ctl), 32'd0);
    cyc();
    chk("prio_idle_ctl", 32'(ctl), 32'd0);
    cyc();
    chk("prio_load_ctl", 32'(ctl), 32'(C_LOAD | C_SFT | C_CAP));
    traregbit = 1'b0;
    initreqr = 1'b1;
    cyc();
    initreqr = 1'b0;
    cyc();
    chk("final_idle_ctl", 32'(ctl), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
